// File: rtl/sreg_pkg.sv
// rtl/sreg_pkg.sv - shared defaults, select encoding and select decoder for the special-register bank
package sreg_pkg;

  localparam int DEF_DATA_W   = 18;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_SEL_W    = 4;

  // Select value meaning "no register" for write/increment fields
  localparam logic [DEF_SEL_W-1:0] SEL_NONE = '0;

  typedef struct packed {
    logic        valid;
    logic [31:0] idx;
  } sel_dec_t;

  // Decode a 1-based write/increment select k into register index k-1;
  // zero and anything beyond num_regs decode as invalid.
  function automatic sel_dec_t sel_to_idx(input logic [31:0] sel, input logic [31:0] num_regs);
    sel_dec_t d;
    d.valid = (sel != 32'(SEL_NONE)) && (sel <= num_regs);
    d.idx   = sel - 32'd1;
    return d;
  endfunction

endpackage

// File: rtl/sreg_if.sv
// rtl/sreg_if.sv - microcode-side control and observation signals of the special-register bank
interface sreg_if #(
  parameter int DATA_W = 18,
  parameter int SEL_W  = 4
);

  logic [SEL_W-1:0]  wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic [SEL_W-1:0]  inc_sel;
  logic [SEL_W-1:0]  rd_sel;
  logic [DATA_W-1:0] rd_data;
  logic [SEL_W-1:0]  cmp_a_sel;
  logic [SEL_W-1:0]  cmp_b_sel;
  logic              eq_flag;
  logic              lt_flag;
  logic              inc_wrap;
  logic              save;
  logic              restore;
  logic              clr_all;

  modport master (
    output wr_sel, wr_data, inc_sel, rd_sel, cmp_a_sel, cmp_b_sel, save, restore, clr_all,
    input  rd_data, eq_flag, lt_flag, inc_wrap
  );

  modport slave (
    input  wr_sel, wr_data, inc_sel, rd_sel, cmp_a_sel, cmp_b_sel, save, restore, clr_all,
    output rd_data, eq_flag, lt_flag, inc_wrap
  );

endinterface

// File: rtl/sreg_cell.sv
// rtl/sreg_cell.sv - one special register with its save/restore shadow and increment
module sreg_cell #(
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              restore_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              inc_en_i,
  input  logic              save_i,
  output logic [DATA_W-1:0] q_o,
  output logic              wrap_o
);

  logic [DATA_W-1:0] val_q, val_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;

  // Next value in priority clear > restore > write > increment; the shadow
  // always samples the pre-update value so save+restore swaps the two banks.
  always_comb begin
    val_d    = val_q;
    wrap_o   = 1'b0;
    shadow_d = save_i ? val_q : shadow_q;
    if (clr_i) begin
      val_d = '0;
    end else if (restore_i) begin
      val_d = shadow_q;
    end else if (wr_en_i) begin
      val_d = wr_data_i;
    end else if (inc_en_i) begin
      val_d  = val_q + DATA_W'(1);
      wrap_o = &val_q;
    end
  end

  // Register and shadow storage with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      val_q    <= '0;
      shadow_q <= '0;
    end else begin
      val_q    <= val_d;
      shadow_q <= shadow_d;
    end
  end

  assign q_o = val_q;

endmodule

// File: rtl/sreg_bank.sv
// rtl/sreg_bank.sv - parametrised special-register bank with increment, shadow bank and compare flags
module sreg_bank
  import sreg_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int SEL_W    = DEF_SEL_W
) (
  input  logic clk,
  input  logic rst_n,
  sreg_if.slave bus
);

  logic [DATA_W-1:0]   q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_en;
  logic [NUM_REGS-1:0] inc_en;
  logic [NUM_REGS-1:0] cell_wrap;
  sel_dec_t            wr_dec;
  sel_dec_t            inc_dec;

  logic [DATA_W-1:0]   rd_data;
  logic [DATA_W-1:0]   cmp_a;
  logic [DATA_W-1:0]   cmp_b;

  logic eq_q, eq_d;
  logic lt_q, lt_d;
  logic wrap_q, wrap_d;

  assign wr_dec  = sel_to_idx(32'(bus.wr_sel), 32'(NUM_REGS));
  assign inc_dec = sel_to_idx(32'(bus.inc_sel), 32'(NUM_REGS));

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
    assign wr_en[i]  = wr_dec.valid && (wr_dec.idx == 32'(i));
    assign inc_en[i] = inc_dec.valid && (inc_dec.idx == 32'(i));

    sreg_cell #(
      .DATA_W (DATA_W)
    ) u_cell (
      .clk       (clk),
      .rst_n_i   (rst_n),
      .clr_i     (bus.clr_all),
      .restore_i (bus.restore),
      .wr_en_i   (wr_en[i]),
      .wr_data_i (bus.wr_data),
      .inc_en_i  (inc_en[i]),
      .save_i    (bus.save),
      .q_o       (q[i]),
      .wrap_o    (cell_wrap[i])
    );
  end

  // Read port and compare operands: 0-based selects, out-of-range reads 0
  always_comb begin
    rd_data = '0;
    cmp_a   = '0;
    cmp_b   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(bus.rd_sel) == 32'(i))    rd_data = q[i];
      if (32'(bus.cmp_a_sel) == 32'(i)) cmp_a   = q[i];
      if (32'(bus.cmp_b_sel) == 32'(i)) cmp_b   = q[i];
    end
  end

  // Flag next-state from pre-update register values; wrap only from an applied increment
  always_comb begin
    eq_d   = (cmp_a == cmp_b);
    lt_d   = (cmp_a < cmp_b);
    wrap_d = |cell_wrap;
  end

  // Registered one-cycle flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eq_q   <= 1'b0;
      lt_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      eq_q   <= eq_d;
      lt_q   <= lt_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.rd_data  = rd_data;
  assign bus.eq_flag  = eq_q;
  assign bus.lt_flag  = lt_q;
  assign bus.inc_wrap = wrap_q;

endmodule

// File: tb/tb_sreg_bank.sv
// tb/tb_sreg_bank.sv - directed self-checking bench for the special-register bank
module tb_sreg_bank;

  localparam int DW = 18;
  localparam int NR = 8;
  localparam int SW = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [DW-1:0] got;

  sreg_if #(.DATA_W(DW), .SEL_W(SW)) bus ();

  sreg_bank #(.DATA_W(DW), .NUM_REGS(NR), .SEL_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_sel  = '0;
    bus.wr_data = '0;
    bus.inc_sel = '0;
    bus.save    = 1'b0;
    bus.restore = 1'b0;
    bus.clr_all = 1'b0;
  endtask

  task automatic rd(input int sel, output logic [DW-1:0] v);
    bus.rd_sel = SW'(sel);
    #1;
    v = bus.rd_data;
  endtask

  task automatic wr(input int sel, input logic [DW-1:0] data);
    bus.wr_sel  = SW'(sel);
    bus.wr_data = data;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.rd_sel = '0; bus.cmp_a_sel = 4'd1; bus.cmp_b_sel = 4'd1;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) begin
      rd(i, got);
      checks++;
      if (got !== '0) begin $display("FAIL reset_reg%0d got=%h exp=0", i, got); errors++; end
    end
    checks++;
    if ({bus.eq_flag, bus.lt_flag, bus.inc_wrap} !== 3'b000) begin
      $display("FAIL reset_flags got=%b exp=000", {bus.eq_flag, bus.lt_flag, bus.inc_wrap}); errors++;
    end
  endtask

  task automatic test_write();
    bus.wr_sel = 4'd3; bus.wr_data = 18'h2A5;
    rd(2, got);
    checks++;
    if (got !== 18'h0) begin $display("FAIL no_bypass got=%h exp=0", got); errors++; end
    step(); idle();
    rd(2, got);
    checks++;
    if (got !== 18'h2A5) begin $display("FAIL write_r2 got=%h exp=2a5", got); errors++; end
    wr(10, 18'h111);
    wr(0, 18'h222);
    rd(2, got);
    checks++;
    if (got !== 18'h2A5) begin $display("FAIL bad_wr_sel_r2 got=%h exp=2a5", got); errors++; end
    rd(1, got);
    checks++;
    if (got !== 18'h0) begin $display("FAIL bad_wr_sel_r1 got=%h exp=0", got); errors++; end
    rd(9, got);
    checks++;
    if (got !== 18'h0) begin $display("FAIL rd_out_of_range got=%h exp=0", got); errors++; end
  endtask

  task automatic test_inc_wrap();
    wr(1, 18'h3FFFF);
    bus.inc_sel = 4'd1; step(); idle();
    rd(0, got);
    checks++;
    if (got !== 18'h0) begin $display("FAIL inc_wrap_val got=%h exp=0", got); errors++; end
    checks++;
    if (bus.inc_wrap !== 1'b1) begin $display("FAIL inc_wrap_pulse got=%b exp=1", bus.inc_wrap); errors++; end
    step();
    checks++;
    if (bus.inc_wrap !== 1'b0) begin $display("FAIL inc_wrap_clear got=%b exp=0", bus.inc_wrap); errors++; end
    bus.inc_sel = 4'd1; step(); idle();
    rd(0, got);
    checks++;
    if (got !== 18'h1) begin $display("FAIL inc_second got=%h exp=1", got); errors++; end
    checks++;
    if (bus.inc_wrap !== 1'b0) begin $display("FAIL inc_second_wrap got=%b exp=0", bus.inc_wrap); errors++; end
    bus.inc_sel = 4'd12; step(); idle();
    rd(0, got);
    checks++;
    if (got !== 18'h1) begin $display("FAIL inc_bad_sel got=%h exp=1", got); errors++; end
  endtask

  task automatic test_wr_inc();
    wr(2, 18'h3FFFF);
    bus.wr_sel = 4'd2; bus.inc_sel = 4'd2; bus.wr_data = 18'd5;
    step(); idle();
    rd(1, got);
    checks++;
    if (got !== 18'd5) begin $display("FAIL same_reg_write_wins got=%h exp=5", got); errors++; end
    checks++;
    if (bus.inc_wrap !== 1'b0) begin $display("FAIL same_reg_no_wrap got=%b exp=0", bus.inc_wrap); errors++; end
    wr(3, 18'd7);
    bus.wr_sel = 4'd2; bus.inc_sel = 4'd3; bus.wr_data = 18'd9;
    step(); idle();
    rd(1, got);
    checks++;
    if (got !== 18'd9) begin $display("FAIL diff_reg_write got=%h exp=9", got); errors++; end
    rd(2, got);
    checks++;
    if (got !== 18'd8) begin $display("FAIL diff_reg_inc got=%h exp=8", got); errors++; end
  endtask

  task automatic test_save_restore();
    for (int i = 0; i < NR; i++) wr(i + 1, DW'(i + 1));
    bus.save = 1'b1; bus.clr_all = 1'b1; bus.inc_sel = 4'd1;
    step(); idle();
    for (int i = 0; i < NR; i++) begin
      rd(i, got);
      checks++;
      if (got !== '0) begin $display("FAIL clr_reg%0d got=%h exp=0", i, got); errors++; end
    end
    bus.restore = 1'b1; step(); idle();
    for (int i = 0; i < NR; i++) begin
      rd(i, got);
      checks++;
      if (got !== DW'(i + 1)) begin $display("FAIL restore_reg%0d got=%h exp=%h", i, got, DW'(i + 1)); errors++; end
    end
    for (int i = 0; i < NR; i++) wr(i + 1, DW'(32'h100 + i));
    bus.save = 1'b1; bus.restore = 1'b1; step(); idle();
    for (int i = 0; i < NR; i++) begin
      rd(i, got);
      checks++;
      if (got !== DW'(i + 1)) begin $display("FAIL swap_reg%0d got=%h exp=%h", i, got, DW'(i + 1)); errors++; end
    end
    bus.restore = 1'b1; step(); idle();
    rd(5, got);
    checks++;
    if (got !== 18'h105) begin $display("FAIL swap_shadow got=%h exp=105", got); errors++; end
  endtask

  task automatic test_compare();
    wr(5, 18'd10);
    wr(7, 18'd10);
    bus.cmp_a_sel = 4'd4; bus.cmp_b_sel = 4'd6;
    step();
    checks++;
    if ({bus.eq_flag, bus.lt_flag} !== 2'b10) begin $display("FAIL cmp_equal got=%b exp=10", {bus.eq_flag, bus.lt_flag}); errors++; end
    wr(5, 18'd9);
    checks++;
    if ({bus.eq_flag, bus.lt_flag} !== 2'b10) begin $display("FAIL cmp_pre_update got=%b exp=10", {bus.eq_flag, bus.lt_flag}); errors++; end
    step();
    checks++;
    if ({bus.eq_flag, bus.lt_flag} !== 2'b01) begin $display("FAIL cmp_less got=%b exp=01", {bus.eq_flag, bus.lt_flag}); errors++; end
    bus.cmp_a_sel = 4'd6; bus.cmp_b_sel = 4'd4; step();
    checks++;
    if ({bus.eq_flag, bus.lt_flag} !== 2'b00) begin $display("FAIL cmp_greater got=%b exp=00", {bus.eq_flag, bus.lt_flag}); errors++; end
    bus.cmp_a_sel = 4'd15; bus.cmp_b_sel = 4'd6; step();
    checks++;
    if ({bus.eq_flag, bus.lt_flag} !== 2'b01) begin $display("FAIL cmp_a_oor got=%b exp=01", {bus.eq_flag, bus.lt_flag}); errors++; end
    bus.cmp_b_sel = 4'd9; step();
    checks++;
    if ({bus.eq_flag, bus.lt_flag} !== 2'b10) begin $display("FAIL cmp_both_oor got=%b exp=10", {bus.eq_flag, bus.lt_flag}); errors++; end
  endtask

  task automatic test_mid_reset();
    wr(2, 18'h3FFFF);
    bus.cmp_a_sel = 4'd1; bus.cmp_b_sel = 4'd1;
    rst_n = 1'b0;
    bus.wr_sel = 4'd1; bus.wr_data = 18'h55; bus.inc_sel = 4'd2; bus.save = 1'b1;
    step();
    rst_n = 1'b1; idle();
    bus.cmp_a_sel = 4'd0; bus.cmp_b_sel = 4'd0;
    for (int i = 0; i < NR; i++) begin
      rd(i, got);
      checks++;
      if (got !== '0) begin $display("FAIL midrst_reg%0d got=%h exp=0", i, got); errors++; end
    end
    checks++;
    if ({bus.eq_flag, bus.lt_flag, bus.inc_wrap} !== 3'b000) begin
      $display("FAIL midrst_flags got=%b exp=000", {bus.eq_flag, bus.lt_flag, bus.inc_wrap}); errors++;
    end
    bus.restore = 1'b1; step(); idle();
    for (int i = 0; i < NR; i++) begin
      rd(i, got);
      checks++;
      if (got !== '0) begin $display("FAIL midrst_shadow%0d got=%h exp=0", i, got); errors++; end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle();
    bus.rd_sel = '0; bus.cmp_a_sel = '0; bus.cmp_b_sel = '0;
    test_reset();
    test_write();
    test_inc_wrap();
    test_wr_inc();
    test_save_restore();
    test_compare();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sreg_bank.md
# sreg_bank

Parametrised special-register bank for the microcoded datapath. It replaces the fixed set of eight single-purpose loop/address registers and their separate write-select decoder. It holds NUM_REGS registers of DATA_W bits, with one decoded write port and one combinational read port feeding the ALU A-side mux. Beyond plain storage it adds per-register increment for loop counters, a one-cycle save/restore shadow bank for microcode subroutines, and registered compare flags for loop-bound tests.

## Interface
- DATA_W, 18, register width (matches ALU bus)
- NUM_REGS, 8, number of registers (1..2**SEL_W-1)
- SEL_W, 4, width of every select field (microinstruction field width)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- wr_sel  in  SEL_W  0 = no write; k in 1..NUM_REGS writes register k-1; other values are no-ops
- wr_data  in  DATA_W  write data (ALU result bus)
- inc_sel  in  SEL_W  same encoding as wr_sel; selected register += 1
- rd_sel  in  SEL_W  0..NUM_REGS-1 selects a register; other values read 0
- rd_data  out  DATA_W  combinational read of the selected register
- cmp_a_sel, cmp_b_sel  in  SEL_W  compare operands, same encoding as rd_sel
- eq_flag  out  1  registered: A == B
- lt_flag  out  1  registered: A < B, unsigned
- inc_wrap  out  1  registered one-cycle pulse: the last increment wrapped
- save  in  1  copy all registers to the shadow bank
- restore  in  1  copy the shadow bank to all registers
- clr_all  in  1  zero all registers (shadow is untouched)

## Operation
- Reset (rst_n=0 at a clk edge): all registers = 0, all shadows = 0, eq_flag = 0, lt_flag = 0, inc_wrap = 0. rd_data therefore reads 0.
- Per-cycle register update, in priority order:
  - clr_all
  - restore
  - write and increment. Write and increment apply in the same cycle when they target different registers. When they target the same register, the write wins and there is no increment and no wrap.
- save is independent of the register update. The shadow captures the pre-update register values on the same edge.
  - save and restore together: the registers load the old shadow, and the shadow loads the old registers (swap).
  - save and clr_all together: the shadow captures the old values, and the registers go to 0.
- Increment is modulo 2**DATA_W. All-ones + 1 = 0, and inc_wrap = 1 on the following cycle.
  - inc_wrap is not raised if the increment is suppressed by a write, clr_all or restore.
- Flags are computed each cycle from the pre-update register values selected by cmp_a_sel and cmp_b_sel.
  - An out-of-range select reads as 0 for comparison.
- Out-of-range wr_sel or inc_sel is ignored silently. No error output.

## Timing
- Write/increment/clear/restore: the new value is visible on rd_data in the cycle after the edge. There is no write-to-read bypass, so reading the register being written returns the old value that cycle.
- rd_data: combinational from storage and rd_sel, zero cycles.
- eq_flag / lt_flag / inc_wrap: 1-cycle latency, valid for exactly one cycle per evaluation.
- Reset asserted mid-operation overrides every other input on that edge. Inputs sampled in the same cycle are discarded.
- No handshake. All controls are single-cycle level inputs sampled at every edge.

## Structure
- Package sreg_pkg:
  - defaults DATA_W, NUM_REGS, SEL_W
  - SEL_NONE = 0
  - function sel_to_idx (decode k to k-1 with a valid bit)
- Sub-module sreg_cell: one register plus its shadow, with inputs clr, rst, wr_en, inc_en, save, restore and outputs q and wrap. sreg_bank instantiates NUM_REGS cells via generate, plus the read mux and the compare logic.

## Test plan
- Reset, then wr_sel=3, wr_data=0x2A5 -> the next cycle rd_sel=2 gives 0x2A5. With the same edge, rd_sel=2 still reads 0.
- Register 0 = 0x3FFFF, inc_sel=1 -> register 0 = 0 and inc_wrap=1 for one cycle. A second increment gives 1 and inc_wrap=0.
- wr_sel=2, inc_sel=2, wr_data=5 -> register 1 = 5, no wrap. wr_sel=2, inc_sel=3 -> register 1 written and register 2 incremented in the same cycle.
- Regs r0..r7 = 1..8, save, clr_all -> all regs 0. restore -> regs read 1..8 again. save and restore together -> regs and shadow swap.
- r4=10, r6=10, cmp_a_sel=4, cmp_b_sel=6 -> eq_flag=1, lt_flag=0 one cycle later. r4=9 -> eq=0, lt=1. cmp_a_sel=15 -> A reads 0.
- Mid-sequence rst_n=0 with wr_sel, inc_sel and save all active -> every register, shadow and flag is 0 the next cycle.
